// File: rtl/pwm_ramp_sched.sv
// -----------------------------------------------------------------------------
// pwm_ramp_sched
//   Duty-cycle sequencer for the PWM datapath. A target duty word arrives either
//   by valid/ready handshake or as debounced inc/dec pulses. dc_out is then
//   ramped toward that target in steps of at most STEP. A step is taken only
//   after TICK_DIV clk cycles, and only on a PWM period boundary, so the
//   comparator never sees a change in the middle of a period.
//
// Optional feature (compile-time macro PWM_SOFTSTART_EN):
//   When defined, reset leaves dc_out at MIN_DC with the FSM already ramping.
//   After reset is released the block ramps up to RESET_DC, pulses done and
//   then goes idle. When undefined, reset leaves dc_out at RESET_DC, idle.
//
// Ports
//   clk           in   1  system clock, rising edge
//   rst           in   1  asynchronous reset, active low (0 = reset)
//   cmd_valid     in   1  target command present
//   cmd_target    in   W  requested duty, clamped to [MIN_DC, MAX_DC]
//   cmd_ready     out  1  high while idle; command taken when valid & ready
//   inc_pulse     in   1  request target = dc_out + STEP (clamped)
//   dec_pulse     in   1  request target = dc_out - STEP (clamped)
//   period_start  in   1  PWM counter wrap pulse
//   dc_out        out  W  duty word to the PWM comparator
//   dc_upd        out  1  pulse: dc_out holds a new value this cycle
//   busy          out  1  ramp in progress
//   done          out  1  pulse: dc_out has reached the target
// -----------------------------------------------------------------------------
module pwm_ramp_sched #(
  parameter int unsigned W        = 32,
  parameter int unsigned MIN_DC   = 5_000,
  parameter int unsigned MAX_DC   = 150_000,
  parameter int unsigned RESET_DC = 25_000,
  parameter int unsigned STEP     = 5_000,
  parameter int unsigned TICK_DIV = 2_500_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [W-1:0] cmd_target,
  output logic         cmd_ready,
  input  logic         inc_pulse,
  input  logic         dec_pulse,
  input  logic         period_start,
  output logic [W-1:0] dc_out,
  output logic         dc_upd,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_TICK   = 2'd1,
    S_WAIT_PERIOD = 2'd2
  } state_t;

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // All duty arithmetic is carried one bit wider than W so sums cannot wrap.
  localparam logic [W:0]    L_MIN       = (W+1)'(MIN_DC);
  localparam logic [W:0]    L_MAX       = (W+1)'(MAX_DC);
  localparam logic [W:0]    L_STEP      = (W+1)'(STEP);
  localparam logic [TW-1:0] L_TICK_LAST = TW'(TICK_DIV - 1);

`ifdef PWM_SOFTSTART_EN
  localparam logic [W-1:0]  L_RST_DC    = W'(MIN_DC);
  localparam state_t        L_RST_STATE = S_WAIT_TICK;
`else
  localparam logic [W-1:0]  L_RST_DC    = W'(RESET_DC);
  localparam state_t        L_RST_STATE = S_IDLE;
`endif

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_dc;
  logic [W-1:0]  r_target;
  logic [TW-1:0] r_tick_cnt;
  logic          r_done;
  logic          r_dc_upd;

  logic [W:0]    w_dc_ext;
  logic [W:0]    w_tgt_ext;
  logic [W:0]    w_cmd_ext;
  logic [W:0]    w_cmd_clamped;
  logic [W:0]    w_inc_sum;
  logic [W:0]    w_inc_tgt;
  logic [W:0]    w_dec_tgt;
  logic [W:0]    w_new_tgt;
  logic [W:0]    w_diff;
  logic [W:0]    w_delta;
  logic [W:0]    w_step_dc;
  logic          w_up;
  logic          w_accept;
  logic          w_tick_last;
  logic          w_step_fire;

  assign w_dc_ext  = {1'b0, r_dc};
  assign w_tgt_ext = {1'b0, r_target};
  assign w_cmd_ext = {1'b0, cmd_target};

  assign w_cmd_clamped = (w_cmd_ext < L_MIN) ? L_MIN :
                         (w_cmd_ext > L_MAX) ? L_MAX : w_cmd_ext;
  assign w_inc_sum     = w_dc_ext + L_STEP;
  assign w_inc_tgt     = (w_inc_sum > L_MAX) ? L_MAX : w_inc_sum;
  // Compare before subtracting so the decrement can never underflow.
  assign w_dec_tgt     = (w_dc_ext < (L_MIN + L_STEP)) ? L_MIN : (w_dc_ext - L_STEP);

  // Command beats inc beats dec; inc together with dec (no command) cancels.
  assign w_accept  = (r_state == S_IDLE) && (cmd_valid || (inc_pulse ^ dec_pulse));
  assign w_new_tgt = cmd_valid ? w_cmd_clamped :
                     inc_pulse ? w_inc_tgt : w_dec_tgt;

  // Step toward target by min(STEP, |target - dc|): lands exactly, no overshoot.
  assign w_up        = (w_tgt_ext > w_dc_ext);
  assign w_diff      = w_up ? (w_tgt_ext - w_dc_ext) : (w_dc_ext - w_tgt_ext);
  assign w_delta     = (w_diff > L_STEP) ? L_STEP : w_diff;
  assign w_step_dc   = w_up ? (w_dc_ext + w_delta) : (w_dc_ext - w_delta);

  assign w_tick_last = (r_tick_cnt == L_TICK_LAST);
  // Only a period_start seen while already in WAIT_PERIOD counts; one arriving
  // on the cycle the tick expires is still in WAIT_TICK and is skipped.
  assign w_step_fire = (r_state == S_WAIT_PERIOD) && period_start;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= L_RST_STATE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (w_new_tgt != w_dc_ext)) w_next = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (w_tick_last) w_next = S_WAIT_PERIOD;
      end
      S_WAIT_PERIOD: begin
        if (period_start) w_next = (w_step_dc == w_tgt_ext) ? S_IDLE : S_WAIT_TICK;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
  end

  // Duty, target, tick counter and event pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dc       <= L_RST_DC;
      r_target   <= W'(RESET_DC);
      r_tick_cnt <= '0;
      r_done     <= 1'b0;
      r_dc_upd   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_dc_upd <= 1'b0;
      if (w_accept) begin
        r_target   <= w_new_tgt[W-1:0];
        r_tick_cnt <= '0;
        if (w_new_tgt == w_dc_ext) r_done <= 1'b1;
      end
      if (r_state == S_WAIT_TICK) begin
        r_tick_cnt <= w_tick_last ? '0 : (r_tick_cnt + 1'b1);
      end
      if (w_step_fire) begin
        r_dc     <= w_step_dc[W-1:0];
        r_dc_upd <= 1'b1;
        if (w_step_dc == w_tgt_ext) r_done <= 1'b1;
      end
    end
  end

  assign dc_out = r_dc;
  assign dc_upd = r_dc_upd;
  assign done   = r_done;

endmodule

// File: tb/tb_pwm_ramp_sched.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_sched
//   Directed bench for pwm_ramp_sched with TICK_DIV=4, STEP=5_000 and a
//   period_start pulse every 10 clk cycles. Inputs change and outputs are
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_sched;

  localparam int W    = 32;
  localparam int TICK = 4;
  localparam int STEP = 5_000;

`ifdef PWM_SOFTSTART_EN
  localparam int RST_DC    = 5_000;
  localparam int RST_BUSY  = 1;
`else
  localparam int RST_DC    = 25_000;
  localparam int RST_BUSY  = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic [W-1:0] cmd_target;
  logic         cmd_ready;
  logic         inc_pulse;
  logic         dec_pulse;
  logic         period_start;
  logic [W-1:0] dc_out;
  logic         dc_upd;
  logic         busy;
  logic         done;

  int pcnt = 0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pcnt <= (pcnt == 9) ? 0 : pcnt + 1;
  assign period_start = (pcnt == 9);

  pwm_ramp_sched #(
    .W        (W),
    .MIN_DC   (5_000),
    .MAX_DC   (150_000),
    .RESET_DC (25_000),
    .STEP     (STEP),
    .TICK_DIV (TICK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_target   (cmd_target),
    .cmd_ready    (cmd_ready),
    .inc_pulse    (inc_pulse),
    .dec_pulse    (dec_pulse),
    .period_start (period_start),
    .dc_out       (dc_out),
    .dc_upd       (dc_upd),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next dc_upd pulse and check the new duty, the done
  // flag, alignment to the period boundary, and that dc_out held still before.
  task automatic wait_upd(input string tag, input int exp_dc, input bit exp_done);
    logic [W-1:0] prev;
    bit seen;
    bit glitch;
    prev   = dc_out;
    seen   = 1'b0;
    glitch = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (dc_upd === 1'b1) seen = 1'b1;
      else if (dc_out !== prev) glitch = 1'b1;
    end
    check({tag, " upd_seen"}, seen, 1);
    check({tag, " dc_out"}, dc_out, exp_dc);
    check({tag, " done"}, done, exp_done);
    check({tag, " on_period"}, (pcnt == 0), 1);
    check({tag, " no_glitch"}, glitch, 0);
  endtask

  task automatic send_cmd(input int tgt);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  // Watch n cycles and report whether any dc_upd pulse occurred.
  task automatic quiet(input int n, output bit any_upd);
    any_upd = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (dc_upd !== 1'b0) any_upd = 1'b1;
    end
  endtask

  initial begin
    int  exp_dc;
    bit  any;

    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = '0;
    inc_pulse  = 1'b0;
    dec_pulse  = 1'b0;

    // 1: reset values
    repeat (3) @(negedge clk);
    check("rst dc_out", dc_out, RST_DC);
    check("rst cmd_ready", cmd_ready, 1 - RST_BUSY);
    check("rst busy", busy, RST_BUSY);
    check("rst done", done, 0);
    check("rst dc_upd", dc_upd, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst dc_out", dc_out, RST_DC);
`ifdef PWM_SOFTSTART_EN
    wait_upd("soft1", 10_000, 0);
    wait_upd("soft2", 15_000, 0);
    wait_upd("soft3", 20_000, 0);
    wait_upd("soft4", 25_000, 1);
    @(negedge clk);
`endif
    check("idle busy", busy, 0);
    check("idle cmd_ready", cmd_ready, 1);

    // 2: ramp up to 40_000
    send_cmd(40_000);
    check("t2 busy", busy, 1);
    check("t2 cmd_ready", cmd_ready, 0);
    wait_upd("t2a", 30_000, 0);
    wait_upd("t2b", 35_000, 0);
    wait_upd("t2c", 40_000, 1);
    check("t2 busy_end", busy, 0);
    @(negedge clk);
    check("t2 done_1cyc", done, 0);

    // 3: ramp down, then a partial step
    send_cmd(25_000);
    wait_upd("t3a", 35_000, 0);
    wait_upd("t3b", 30_000, 0);
    wait_upd("t3c", 25_000, 1);
    send_cmd(27_000);
    wait_upd("t3 partial", 27_000, 1);

    // 4: clamp at MAX, inc at MAX, clamp at MIN, dec at MIN
    send_cmd(200_000);
    exp_dc = 27_000;
    while (exp_dc != 150_000) begin
      exp_dc = (exp_dc + STEP > 150_000) ? 150_000 : exp_dc + STEP;
      wait_upd("t4 up", exp_dc, exp_dc == 150_000);
    end
    @(negedge clk);
    inc_pulse = 1'b1;
    @(negedge clk);
    inc_pulse = 1'b0;
    check("t4 inc_max done", done, 1);
    check("t4 inc_max dc", dc_out, 150_000);
    check("t4 inc_max upd", dc_upd, 0);
    check("t4 inc_max busy", busy, 0);
    send_cmd(0);
    exp_dc = 150_000;
    while (exp_dc != 5_000) begin
      exp_dc = exp_dc - STEP;
      wait_upd("t4 down", exp_dc, exp_dc == 5_000);
    end
    @(negedge clk);
    dec_pulse = 1'b1;
    @(negedge clk);
    dec_pulse = 1'b0;
    check("t4 dec_min done", done, 1);
    check("t4 dec_min dc", dc_out, 5_000);
    check("t4 dec_min upd", dc_upd, 0);
    check("t4 dec_min busy", busy, 0);

    // 5: priority and ignore rules
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = 15_000;
    inc_pulse  = 1'b1;
    dec_pulse  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
    inc_pulse  = 1'b0;
    dec_pulse  = 1'b0;
    check("t5 prio busy", busy, 1);
    wait_upd("t5 prio a", 10_000, 0);
    wait_upd("t5 prio b", 15_000, 1);
    @(negedge clk);
    inc_pulse = 1'b1;
    dec_pulse = 1'b1;
    @(negedge clk);
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;
    check("t5 both done", done, 0);
    check("t5 both busy", busy, 0);
    quiet(30, any);
    check("t5 both no_upd", any, 0);
    check("t5 both dc", dc_out, 15_000);
    inc_pulse = 1'b1;
    @(negedge clk);
    inc_pulse = 1'b0;
    check("t5 inc busy", busy, 1);
    dec_pulse = 1'b1;
    @(negedge clk);
    dec_pulse  = 1'b0;
    cmd_valid  = 1'b1;
    cmd_target = 100_000;
    @(negedge clk);
    cmd_valid  = 1'b0;
    wait_upd("t5 inc", 20_000, 1);
    check("t5 inc busy_end", busy, 0);
    quiet(30, any);
    check("t5 ignored no_upd", any, 0);
    check("t5 ignored dc", dc_out, 20_000);

    // 6: reset while waiting for a period boundary at 35_000
    send_cmd(40_000);
    wait_upd("t6a", 25_000, 0);
    wait_upd("t6b", 30_000, 0);
    wait_upd("t6c", 35_000, 0);
    repeat (TICK + 1) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6 rst dc", dc_out, RST_DC);
    check("t6 rst busy", busy, RST_BUSY);
    check("t6 rst cmd_ready", cmd_ready, 1 - RST_BUSY);
    check("t6 rst dc_upd", dc_upd, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
